cim_bus_receiver: RTL and testbench



---
 rtl/cim_bus_receiver_pkg.sv | 46 ++++
 rtl/cim_bus_receiver_if.sv | 16 +
 rtl/cim_bus_receiver_rx_word_buffer.sv | 66 ++++++
 rtl/cim_bus_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_cim_bus_receiver.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_bus_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cim_bus_receiver_pkg
// Brief    : Shared types for the CiM tile bus receiver: broadcast bus word,
//            op encoding, receiver FSM states and a word-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package cim_bus_receiver_pkg;

  localparam int N_STORAGE    = 16;                 // bits per bus data word
  localparam int NUM_CIMS     = 60;                 // tiles on the shared bus
  localparam int BUS_OP_WIDTH = 3;
  localparam int CIM_ID_W     = $clog2(NUM_CIMS);   // target_or_sender width
  localparam int BUF_DEPTH    = 3;                  // words per DATA_STREAM_OP

  typedef enum logic [BUS_OP_WIDTH-1:0] {
    NOP                           = 3'd0,
    DATA_STREAM_START_OP          = 3'd1,
    DATA_STREAM_OP                = 3'd2,
    PATCH_LOAD_BROADCAST_START_OP = 3'd3,
    PATCH_LOAD_BROADCAST_OP       = 3'd4
  } bus_op_t;

  typedef logic [N_STORAGE-1:0]                word_t;
  typedef logic [BUF_DEPTH-1:0][N_STORAGE-1:0] word3_t;

  // Data words are signed on the bus but are carried here as raw bits.
  typedef struct packed {
    bus_op_t             op;
    word3_t              data;
    logic [CIM_ID_W-1:0] target_or_sender;
  } bus_t;

  typedef enum logic [1:0] {
    RX_IDLE         = 2'd0,
    RX_PARAM_STREAM = 2'd1,
    RX_PATCH_LOAD   = 2'd2
  } rx_state_t;

  // Number of words of the next instruction that still belong to the stream.
  function automatic logic [1:0] take_count(input word_t remaining);
    return (remaining > N_STORAGE'(BUF_DEPTH)) ? 2'(BUF_DEPTH) : remaining[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cim_bus_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : cim_bus_receiver_if
// Brief    : Shared broadcast bus. The master drives it, every tile listens.
// Revision : 1.0 - initial release
// ============================================================================
interface cim_bus_receiver_if;
  import cim_bus_receiver_pkg::*;

  bus_t pkt;

  modport master (output pkt);
  modport slave  (input  pkt);

endinterface
`default_nettype wire

// File: rtl/cim_bus_receiver_rx_word_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cim_bus_receiver_rx_word_buffer
// Brief    : 3-entry load/drain buffer. A load replaces the whole contents,
//            a drain pops one word per cycle from the head.
// Revision : 1.0 - initial release
// ============================================================================
module cim_bus_receiver_rx_word_buffer
  import cim_bus_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,       // discard everything
  input  logic       load,        // take load_words, valid count load_count
  input  word3_t     load_words,
  input  logic [1:0] load_count,  // 1..3 whenever load is high
  input  logic       drain,       // head word consumed this cycle
  output word_t      head,
  output logic [1:0] count,
  output logic       empty,
  output logic       last
);

  word3_t     words_q, words_d;
  logic [1:0] count_q, count_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;

  // Load overrides drain: the caller only loads when at most the word being
  // drained this very cycle is left, so nothing valid is overwritten.
  always_comb begin
    words_d  = words_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 2'd0;
    end else if (load) begin
      words_d  = load_words;
      count_d  = load_count;
      rd_ptr_d = 2'd0;
    end else if (drain && (count_q != 2'd0)) begin
      count_d  = count_q - 2'd1;
      rd_ptr_d = (count_q == 2'd1) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      words_q  <= words_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head  = words_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign last  = (count_q == 2'd1);

endmodule
`default_nettype wire

// File: rtl/cim_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : cim_bus_receiver
// Brief    : Per-tile bus receiver. Serialises targeted parameter streams
//            into one-word-per-cycle parameter memory writes and keeps this
//            tile's patch out of the broadcast EEG sample stream.
//            Optional feature macro: BUS_RX_ERR_CHECK_EN (sticky rx_err port).
// Revision : 1.0 - initial release
// ============================================================================
module cim_bus_receiver
  import cim_bus_receiver_pkg::*;
#(
  parameter int CIM_ID       = 0,
  parameter int PATCH_LEN    = 64,
  parameter int NUM_SAMPLES  = 3840,
  parameter int PARAM_ADDR_W = 10,
  parameter int DATA_ADDR_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  cim_bus_receiver_if.slave       bus,
  output logic                    param_wr_en,
  output logic [PARAM_ADDR_W-1:0] param_wr_addr,
  output logic                    data_wr_en,
  output logic [DATA_ADDR_W-1:0]  data_wr_addr,
  output logic [N_STORAGE-1:0]    wr_data,
  output logic                    stream_done,
  output logic                    patch_done
`ifdef BUS_RX_ERR_CHECK_EN
  ,
  output logic                    rx_err
`endif
);

  localparam int          SAMPLE_W  = $clog2(NUM_SAMPLES);
  localparam logic [31:0] PATCH_LO  = 32'(CIM_ID * PATCH_LEN);
  localparam logic [31:0] C_PATCH_N = 32'(PATCH_LEN);

  bus_t pkt;
  assign pkt = bus.pkt;

  rx_state_t               state_q, state_d;
  logic [PARAM_ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [PARAM_ADDR_W-1:0] offset_q, offset_d;
  word_t                   remaining_q, remaining_d;
  logic [SAMPLE_W-1:0]     sample_idx_q, sample_idx_d;
  logic                    data_wr_en_q, data_wr_en_d;
  logic [DATA_ADDR_W-1:0]  data_wr_addr_q, data_wr_addr_d;
  word_t                   patch_data_q, patch_data_d;
  logic                    stream_done_q, stream_done_d;
  logic                    patch_done_q, patch_done_d;

  logic       targeted;
  logic       is_start, is_ds, is_pstart, is_psample;
  logic       ds_in_stream, ds_accept;
  logic [1:0] take_n;
  logic [31:0] slot_off;
  logic       in_range;

  word_t      buf_head;
  logic [1:0] buf_count;
  logic       buf_empty, buf_last;

  // Op decode: parameter ops must name this tile, patch ops are broadcast.
  assign targeted     = (pkt.target_or_sender == CIM_ID_W'(CIM_ID));
  assign is_start     = (pkt.op == DATA_STREAM_START_OP) && targeted;
  assign is_ds        = (pkt.op == DATA_STREAM_OP) && targeted;
  assign is_pstart    = (pkt.op == PATCH_LOAD_BROADCAST_START_OP);
  assign is_psample   = (pkt.op == PATCH_LOAD_BROADCAST_OP) && (state_q == RX_PATCH_LOAD);
  assign ds_in_stream = is_ds && (state_q == RX_PARAM_STREAM);
  assign take_n       = take_count(remaining_q);
  // Accept only if at most the word being drained right now is left; once the
  // stream's word count is used up, further instructions carry nothing.
  assign ds_accept    = ds_in_stream && (buf_count <= 2'd1) && (remaining_q != '0);

  // Slot relative to this tile's patch; samples below the patch wrap high.
  assign slot_off = 32'(sample_idx_q) - PATCH_LO;
  assign in_range = (slot_off < C_PATCH_N);

  // The buffer only ever holds words while a parameter stream is running.
  assign param_wr_en   = !buf_empty;
  assign param_wr_addr = base_addr_q + offset_q;
  assign data_wr_en    = data_wr_en_q;
  assign data_wr_addr  = data_wr_addr_q;
  assign wr_data       = data_wr_en_q ? patch_data_q : (param_wr_en ? buf_head : '0);
  assign stream_done   = stream_done_q;
  assign patch_done    = patch_done_q;

  cim_bus_receiver_rx_word_buffer u_rx_word_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (is_start || is_pstart),
    .load       (ds_accept),
    .load_words (pkt.data),
    .load_count (take_n),
    .drain      (param_wr_en),
    .head       (buf_head),
    .count      (buf_count),
    .empty      (buf_empty),
    .last       (buf_last)
  );

  // Next-state, stream bookkeeping and patch write generation.
  always_comb begin
    state_d        = state_q;
    base_addr_d    = base_addr_q;
    offset_d       = offset_q;
    remaining_d    = remaining_q;
    sample_idx_d   = sample_idx_q;
    data_wr_en_d   = 1'b0;
    data_wr_addr_d = '0;
    patch_data_d   = '0;
    stream_done_d  = 1'b0;
    patch_done_d   = data_wr_en_q && (data_wr_addr_q == DATA_ADDR_W'(PATCH_LEN - 1));

    if (is_pstart) begin
      state_d      = RX_PATCH_LOAD;
      sample_idx_d = '0;
      offset_d     = '0;
      remaining_d  = '0;
    end else if (is_start) begin
      base_addr_d = pkt.data[0][PARAM_ADDR_W-1:0];
      remaining_d = pkt.data[1];
      offset_d    = '0;
      if (pkt.data[1] == '0) begin
        state_d       = RX_IDLE;
        stream_done_d = 1'b1;
      end else begin
        state_d = RX_PARAM_STREAM;
      end
    end else begin
      if (param_wr_en) begin
        offset_d = offset_q + PARAM_ADDR_W'(1);
      end
      if (ds_accept) begin
        remaining_d = remaining_q - N_STORAGE'(take_n);
      end
      if (param_wr_en && buf_last && !ds_accept && (remaining_q == '0)) begin
        state_d       = RX_IDLE;
        stream_done_d = 1'b1;
      end
      if (is_psample) begin
        if (in_range) begin
          data_wr_en_d   = 1'b1;
          data_wr_addr_d = slot_off[DATA_ADDR_W-1:0];
          patch_data_d   = pkt.data[0];
        end
        sample_idx_d = sample_idx_q + SAMPLE_W'(1);
        if (sample_idx_q == SAMPLE_W'(NUM_SAMPLES - 1)) begin
          state_d = RX_IDLE;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RX_IDLE;
      base_addr_q    <= '0;
      offset_q       <= '0;
      remaining_q    <= '0;
      sample_idx_q   <= '0;
      data_wr_en_q   <= 1'b0;
      data_wr_addr_q <= '0;
      patch_data_q   <= '0;
      stream_done_q  <= 1'b0;
      patch_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_addr_q    <= base_addr_d;
      offset_q       <= offset_d;
      remaining_q    <= remaining_d;
      sample_idx_q   <= sample_idx_d;
      data_wr_en_q   <= data_wr_en_d;
      data_wr_addr_q <= data_wr_addr_d;
      patch_data_q   <= patch_data_d;
      stream_done_q  <= stream_done_d;
      patch_done_q   <= patch_done_d;
    end
  end

`ifdef BUS_RX_ERR_CHECK_EN
  logic rx_err_q, rx_err_d;
  logic ds_overflow, ds_in_idle;

  assign ds_overflow = ds_in_stream && (buf_count > 2'd1);
  assign ds_in_idle  = is_ds && (state_q == RX_IDLE);
  assign rx_err      = rx_err_q;

  // Sticky error: overflowing instruction or stream word with no stream open.
  always_comb begin
    rx_err_d = rx_err_q | ds_overflow | ds_in_idle;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_err_q <= 1'b0;
    end else begin
      rx_err_q <= rx_err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cim_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cim_bus_receiver
// Brief    : Self-checking bench. Two receivers (CIM_ID 2 and 1) share one
//            bus; expected writes are queued when ops are driven and popped
//            when a write strobe appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cim_bus_receiver;
  import cim_bus_receiver_pkg::*;

  localparam int PATCH_LEN   = 64;
  localparam int NUM_SAMPLES = 3840;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cim_bus_receiver_if u_bus_if ();

  logic        a_param_wr_en, b_param_wr_en;
  logic [9:0]  a_param_wr_addr, b_param_wr_addr;
  logic        a_data_wr_en, b_data_wr_en;
  logic [9:0]  a_data_wr_addr, b_data_wr_addr;
  logic [15:0] a_wr_data, b_wr_data;
  logic        a_stream_done, b_stream_done;
  logic        a_patch_done, b_patch_done;
`ifdef BUS_RX_ERR_CHECK_EN
  logic        a_rx_err, b_rx_err;
`endif

  cim_bus_receiver #(.CIM_ID(2), .PATCH_LEN(PATCH_LEN), .NUM_SAMPLES(NUM_SAMPLES),
                     .PARAM_ADDR_W(10), .DATA_ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .bus(u_bus_if),
    .param_wr_en(a_param_wr_en), .param_wr_addr(a_param_wr_addr),
    .data_wr_en(a_data_wr_en), .data_wr_addr(a_data_wr_addr),
    .wr_data(a_wr_data), .stream_done(a_stream_done), .patch_done(a_patch_done)
`ifdef BUS_RX_ERR_CHECK_EN
    , .rx_err(a_rx_err)
`endif
  );

  cim_bus_receiver #(.CIM_ID(1), .PATCH_LEN(PATCH_LEN), .NUM_SAMPLES(NUM_SAMPLES),
                     .PARAM_ADDR_W(10), .DATA_ADDR_W(10)) dut_b (
    .clk(clk), .rst(rst), .bus(u_bus_if),
    .param_wr_en(b_param_wr_en), .param_wr_addr(b_param_wr_addr),
    .data_wr_en(b_data_wr_en), .data_wr_addr(b_data_wr_addr),
    .wr_data(b_wr_data), .stream_done(b_stream_done), .patch_done(b_patch_done)
`ifdef BUS_RX_ERR_CHECK_EN
    , .rx_err(b_rx_err)
`endif
  );

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          cyc;
    bit          last;
  } wr_exp_t;

  wr_exp_t pq[$];   // expected parameter writes of dut_a
  wr_exp_t dq[$];   // expected patch writes of dut_b

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit sd_pend = 1'b0, pd_pend = 1'b0, zero_len_req = 1'b0;
  int a_param_writes = 0, a_data_writes = 0, a_patch_dones = 0;
  int m_base, m_off, m_rem;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_sd, exp_pd;
    wr_exp_t e;
    if (mon_en) begin
      exp_sd = sd_pend; sd_pend = 1'b0;
      exp_pd = pd_pend; pd_pend = 1'b0;
      chk("a_stream_done", 32'(a_stream_done), 32'(exp_sd));
      chk("b_patch_done", 32'(b_patch_done), 32'(exp_pd));
      chk("b_param_wr_en", 32'(b_param_wr_en), 0);
      chk("b_stream_done", 32'(b_stream_done), 0);
      chk("a_strobe_excl", 32'(a_param_wr_en & a_data_wr_en), 0);
      if (a_param_wr_en === 1'b1) begin
        a_param_writes++;
        chk("param_write_expected", 32'(pq.size() != 0), 1);
        if (pq.size() != 0) begin
          e = pq.pop_front();
          chk("param_addr", 32'(a_param_wr_addr), 32'(e.addr));
          chk("param_data", 32'(a_wr_data), 32'(e.data));
          chk("param_cycle", cyc, e.cyc);
          if (e.last) sd_pend = 1'b1;
        end
      end
      if (b_data_wr_en === 1'b1) begin
        chk("data_write_expected", 32'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("data_slot", 32'(b_data_wr_addr), 32'(e.addr));
          chk("data_value", 32'(b_wr_data), 32'(e.data));
          chk("data_cycle", cyc, e.cyc);
          if (e.last) pd_pend = 1'b1;
        end
      end
      if (a_data_wr_en === 1'b1) begin
        chk("a_data_slot", 32'(a_data_wr_addr), a_data_writes);
        chk("a_data_value", 32'(a_wr_data), 32'(16'((128 + a_data_writes) * 7 + 3)));
        a_data_writes++;
      end
      if (a_patch_done === 1'b1) a_patch_dones++;
      if (zero_len_req) begin
        sd_pend = 1'b1;
        zero_len_req = 1'b0;
      end
    end
  end

  // One bus op, valid for the cycle starting at the next rising edge.
  task automatic drive(input bus_op_t op, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [5:0] tgt);
    @(posedge clk);
    #1;
    u_bus_if.pkt.op               = op;
    u_bus_if.pkt.data[0]          = d0;
    u_bus_if.pkt.data[1]          = d1;
    u_bus_if.pkt.data[2]          = d2;
    u_bus_if.pkt.target_or_sender = tgt;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(NOP, 16'h0, 16'h0, 16'h0, 6'd0);
  endtask

  task automatic param_start(input int addr, input int len, input logic [5:0] tgt);
    drive(DATA_STREAM_START_OP, 16'(addr), 16'(len), 16'h0, tgt);
    if (tgt == 6'd2) begin
      m_base = addr; m_off = 0; m_rem = len;
      if (len == 0) zero_len_req = 1'b1;
    end
  endtask

  task automatic param_op(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                          input logic [5:0] tgt, input bit accept);
    logic [15:0] w [3];
    int n;
    w[0] = w0; w[1] = w1; w[2] = w2;
    drive(DATA_STREAM_OP, w0, w1, w2, tgt);
    if (tgt == 6'd2 && accept) begin
      n = (m_rem > 3) ? 3 : m_rem;
      for (int j = 0; j < n; j++)
        pq.push_back('{addr: 10'(m_base + m_off + j), data: w[j], cyc: cyc + 1 + j,
                       last: (j == n - 1) && (m_rem == n)});
      m_rem -= n;
      m_off += n;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    u_bus_if.pkt = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    // Reset state
    chk("rst_a_param_wr_en", 32'(a_param_wr_en), 0);
    chk("rst_a_param_wr_addr", 32'(a_param_wr_addr), 0);
    chk("rst_a_data_wr_en", 32'(a_data_wr_en), 0);
    chk("rst_a_wr_data", 32'(a_wr_data), 0);
    chk("rst_b_data_wr_addr", 32'(b_data_wr_addr), 0);
    chk("rst_b_param_wr_addr", 32'(b_param_wr_addr), 0);
    chk("rst_a_state", 32'(dut_a.state_q), 32'(RX_IDLE));
`ifdef BUS_RX_ERR_CHECK_EN
    chk("rst_a_rx_err", 32'(a_rx_err), 0);
`endif
    mon_en = 1'b1;

    // Stream of 7 words at 100, instructions 4 cycles apart
    param_start(100, 7, 6'd2);
    param_op(16'h1111, 16'h2222, 16'h3333, 6'd2, 1'b1); idle(3);
    param_op(16'h4444, 16'h5555, 16'h8666, 6'd2, 1'b1); idle(3);
    param_op(16'hF777, 16'hDEAD, 16'hBEEF, 6'd2, 1'b1); idle(4);
    chk("t1_queue_drained", pq.size(), 0);
    chk("t1_writes", a_param_writes, 7);
    chk("t1_state_idle", 32'(dut_a.state_q), 32'(RX_IDLE));

    // Same stream aimed at another tile
    param_start(100, 7, 6'd3);
    param_op(16'h1111, 16'h2222, 16'h3333, 6'd3, 1'b0); idle(3);
    param_op(16'h4444, 16'h5555, 16'h6666, 6'd3, 1'b0); idle(3);
    param_op(16'h7777, 16'h8888, 16'h9999, 6'd3, 1'b0); idle(4);
    chk("t2_no_writes", a_param_writes, 7);
`ifdef BUS_RX_ERR_CHECK_EN
    chk("t2_rx_err_clear", 32'(a_rx_err), 0);
`endif

    // Overflow: second instruction while two words are still undrained
    param_start(200, 6, 6'd2);
    param_op(16'hA000, 16'hA001, 16'hA002, 6'd2, 1'b1); idle(1);
    param_op(16'hBAD0, 16'hBAD1, 16'hBAD2, 6'd2, 1'b0); idle(3);
`ifdef BUS_RX_ERR_CHECK_EN
    chk("t3_rx_err_set", 32'(a_rx_err), 1);
`endif
    chk("t3_still_streaming", 32'(dut_a.state_q), 32'(RX_PARAM_STREAM));
    param_op(16'hC000, 16'hC001, 16'hC002, 6'd2, 1'b1); idle(4);
    chk("t3_queue_drained", pq.size(), 0);

    // Back-to-back drain: next instruction lands as the last word drains
    param_start(1022, 6, 6'd2);
    param_op(16'hD000, 16'hD001, 16'hD002, 6'd2, 1'b1); idle(2);
    param_op(16'hE000, 16'hE001, 16'hE002, 6'd2, 1'b1); idle(5);
    chk("t4_queue_drained", pq.size(), 0);
`ifdef BUS_RX_ERR_CHECK_EN
    chk("t4_rx_err_sticky", 32'(a_rx_err), 1);
`endif

    // Reset in the middle of a drain
    param_start(400, 3, 6'd2);
    drive(DATA_STREAM_OP, 16'h0F01, 16'h0F02, 16'h0F03, 6'd2);
    pq.push_back('{addr: 10'd400, data: 16'h0F01, cyc: cyc + 1, last: 1'b0});
    drive(NOP, 16'h0, 16'h0, 16'h0, 6'd0);
    rst = 1'b1;
    drive(NOP, 16'h0, 16'h0, 16'h0, 6'd0);
    rst = 1'b0;
    idle(3);
    chk("t5_queue_drained", pq.size(), 0);
    chk("t5_state_idle", 32'(dut_a.state_q), 32'(RX_IDLE));
`ifdef BUS_RX_ERR_CHECK_EN
    chk("t5_rx_err_cleared", 32'(a_rx_err), 0);
`endif
    param_start(400, 2, 6'd2);
    param_op(16'h1234, 16'h5678, 16'h9ABC, 6'd2, 1'b1); idle(4);
    chk("t5_restart_drained", pq.size(), 0);

    // Zero-length stream
    param_start(600, 0, 6'd2);
    idle(3);
    chk("t6_state_idle", 32'(dut_a.state_q), 32'(RX_IDLE));

    // Patch load: broadcast every sample of the epoch
    drive(PATCH_LOAD_BROADCAST_START_OP, 16'h0, 16'h0, 16'h0, 6'd63);
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      v = 16'(i * 7 + 3);
      drive(PATCH_LOAD_BROADCAST_OP, v, 16'h0, 16'h0, 6'd0);
      if (i >= PATCH_LEN && i < 2 * PATCH_LEN)
        dq.push_back('{addr: 10'(i - PATCH_LEN), data: v, cyc: cyc + 1,
                       last: (i == 2 * PATCH_LEN - 1)});
    end
    idle(3);
    chk("t7_b_state_idle", 32'(dut_b.state_q), 32'(RX_IDLE));
    chk("t7_a_state_idle", 32'(dut_a.state_q), 32'(RX_IDLE));
    chk("t7_a_data_writes", a_data_writes, PATCH_LEN);
    chk("t7_a_patch_dones", a_patch_dones, 1);
    // A sample after the epoch is over must be ignored
    drive(PATCH_LOAD_BROADCAST_OP, 16'h7FFF, 16'h0, 16'h0, 6'd0);
    idle(3);
    chk("t7_dq_drained", dq.size(), 0);
    chk("t7_a_data_writes_after", a_data_writes, PATCH_LEN);
    chk("end_pq_drained", pq.size(), 0);
`ifdef BUS_RX_ERR_CHECK_EN
    chk("end_b_rx_err", 32'(b_rx_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
